// File: rtl/n64_pi_host.sv
// N64 parallel-interface bus master: address phases, strobed halfword bursts; `N64_PI_HOST_PAGE_SPLIT_EN re-addresses at 512 B pages.
// Latency: T_SETUP+2*T_ALE+T_ALE before the first strobe; each halfword costs high+low strobe time.
// Backpressure: one command at a time (cmd_ready only in IDLE); write bursts stall in VALID until wdata arrives.
module n64_pi_host #(
  parameter int T_SETUP    = 2,
  parameter int T_ALE      = 4,
  parameter int T_STB_LOW  = 8,
  parameter int T_STB_HIGH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [7:0]  cmd_length,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [15:0] wdata,
  output logic        rdata_valid,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        pi_aleh,
  output logic        pi_alel,
  output logic        pi_read,
  output logic        pi_write,
  output logic [15:0] pi_ad_out,
  output logic        pi_ad_oe,
  input  logic [15:0] pi_ad_in
);

  typedef enum logic [2:0] {
    IDLE, SETUP_H, ADDR_H, ADDR_L, VALID_WAIT, STB_HIGH, STB_LOW, FINISH
  } state_t;

  localparam logic [7:0] SETUP_END = 8'(T_SETUP - 1);
  localparam logic [7:0] ALE_END   = 8'(T_ALE - 1);
  localparam logic [7:0] LOW_END   = 8'(T_STB_LOW - 1);
  localparam logic [7:0] HIGH_END  = 8'(T_STB_HIGH - 1);

  state_t      state, state_n;
  logic [7:0]  tmr, tmr_n;
  logic [31:0] addr, addr_n, addr_inc;
  logic [7:0]  remain, remain_n;
  logic        is_write, is_write_n;
  logic        have_data, have_data_n;
  logic        resume, resume_n;
  logic        aleh_n, alel_n, read_n, write_n, oe_n, rdata_valid_n;
  logic [15:0] ad_out_n, rdata_n;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  // Ready only once the previous halfword has been held for the full strobe-high time.
  assign wdata_ready = (state == STB_HIGH) && is_write && !have_data && (tmr == HIGH_END);
  assign addr_inc    = addr + 32'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmr         <= '0;
      addr        <= '0;
      remain      <= '0;
      is_write    <= 1'b0;
      have_data   <= 1'b0;
      resume      <= 1'b0;
      pi_aleh     <= 1'b1;
      pi_alel     <= 1'b0;
      pi_read     <= 1'b1;
      pi_write    <= 1'b1;
      pi_ad_oe    <= 1'b0;
      pi_ad_out   <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      state       <= state_n;
      tmr         <= tmr_n;
      addr        <= addr_n;
      remain      <= remain_n;
      is_write    <= is_write_n;
      have_data   <= have_data_n;
      resume      <= resume_n;
      pi_aleh     <= aleh_n;
      pi_alel     <= alel_n;
      pi_read     <= read_n;
      pi_write    <= write_n;
      pi_ad_oe    <= oe_n;
      pi_ad_out   <= ad_out_n;
      rdata_valid <= rdata_valid_n;
      rdata       <= rdata_n;
    end
  end

  always_comb begin
    state_n       = state;
    tmr_n         = tmr + 8'd1;
    addr_n        = addr;
    remain_n      = remain;
    is_write_n    = is_write;
    have_data_n   = have_data;
    resume_n      = resume;
    aleh_n        = pi_aleh;
    alel_n        = pi_alel;
    read_n        = pi_read;
    write_n       = pi_write;
    oe_n          = pi_ad_oe;
    ad_out_n      = pi_ad_out;
    rdata_valid_n = 1'b0;
    rdata_n       = rdata;
    case (state)
      IDLE: begin
        tmr_n = '0;
        if (cmd_valid) begin
          addr_n     = {cmd_address[31:1], 1'b0};
          is_write_n = cmd_write;
          remain_n   = cmd_length;
          ad_out_n   = cmd_address[31:16];
          oe_n       = 1'b1;
          state_n    = SETUP_H;
        end
      end
      SETUP_H: if (tmr == SETUP_END) begin
        alel_n  = 1'b1;
        tmr_n   = '0;
        state_n = ADDR_H;
      end
      ADDR_H: begin
        if (tmr == SETUP_END) ad_out_n = addr[15:0];
        if (tmr == ALE_END) begin
          aleh_n  = 1'b0;
          tmr_n   = '0;
          state_n = ADDR_L;
        end
      end
      ADDR_L: if (tmr == ALE_END) begin
        alel_n  = 1'b0;
        if (!is_write) oe_n = 1'b0;
        tmr_n   = '0;
        state_n = VALID_WAIT;
      end
      VALID_WAIT: if (tmr == ALE_END) begin
        tmr_n   = '0;
        state_n = STB_HIGH;
      end
      STB_HIGH: begin
        if (is_write) begin
          if (!have_data) begin
            if (tmr == HIGH_END) begin
              tmr_n = tmr;
              if (wdata_valid) begin
                ad_out_n    = wdata;
                have_data_n = 1'b1;
                tmr_n       = '0;
              end
            end
          end else if (tmr == SETUP_END) begin
            write_n     = 1'b0;
            have_data_n = 1'b0;
            tmr_n       = '0;
            state_n     = STB_LOW;
          end
        end else if (tmr == HIGH_END) begin
          read_n  = 1'b0;
          tmr_n   = '0;
          state_n = STB_LOW;
        end
      end
      STB_LOW: if (tmr == LOW_END) begin
        read_n  = 1'b1;
        write_n = 1'b1;
        tmr_n   = '0;
        if (!is_write) begin
          rdata_n       = pi_ad_in;
          rdata_valid_n = 1'b1;
        end
        if (remain == 8'd0) begin
          aleh_n  = 1'b1;
          alel_n  = 1'b0;
          oe_n    = 1'b0;
          state_n = FINISH;
        end else begin
          remain_n = remain - 8'd1;
          addr_n   = addr_inc;
          state_n  = STB_HIGH;
`ifdef N64_PI_HOST_PAGE_SPLIT_EN
          // Crossing into a new 512-byte page needs a fresh address phase.
          if (addr_inc[8:0] == 9'd0) begin
            aleh_n   = 1'b1;
            alel_n   = 1'b0;
            oe_n     = 1'b0;
            resume_n = 1'b1;
            state_n  = FINISH;
          end
`endif
        end
      end
      FINISH: if (tmr == ALE_END) begin
        tmr_n = '0;
        if (resume) begin
          resume_n = 1'b0;
          ad_out_n = addr[31:16];
          oe_n     = 1'b1;
          state_n  = SETUP_H;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_n64_pi_host.sv
// Directed bench for n64_pi_host with a PI device model and scoreboard queues for addresses, read and write data.
module tb_n64_pi_host;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_address = '0;
  logic [7:0]  cmd_length = '0;
  logic        wdata_valid = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] pi_ad_in = '0;
  logic        cmd_ready, wdata_ready, rdata_valid, busy;
  logic [15:0] rdata, pi_ad_out;
  logic        pi_aleh, pi_alel, pi_read, pi_write, pi_ad_oe;

  int n_assert = 0, n_fail = 0;
  logic [31:0] exp_addr_q[$];
  logic [15:0] rd_q[$], wr_q[$], wfeed_q[$];
  int n_phase = 0, n_rpulse = 0, n_wpulse = 0, n_rdv = 0;
  int wcnt = 0, stall_at = -1, stall_len = 0;

  n64_pi_host dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_length(cmd_length),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy),
    .pi_aleh(pi_aleh), .pi_alel(pi_alel), .pi_read(pi_read), .pi_write(pi_write),
    .pi_ad_out(pi_ad_out), .pi_ad_oe(pi_ad_oe), .pi_ad_in(pi_ad_in)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Device model and protocol monitor, evaluated mid-cycle.
  initial begin
    logic p_aleh, p_alel, p_read, p_write, wr_bad;
    logic [15:0] hi, wd;
    int rd_idx;
    p_aleh = 1; p_alel = 0; p_read = 1; p_write = 1; wr_bad = 0;
    hi = '0; wd = '0; rd_idx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pi_alel && !p_alel) hi = pi_ad_out;
        if (!pi_aleh && p_aleh && pi_alel) begin
          n_phase++;
          if (exp_addr_q.size() == 0) chk("unexpected_addr_phase", 1, 0);
          else chk("addr_phase", {hi, pi_ad_out}, exp_addr_q.pop_front());
        end
        if (!pi_read || !pi_write)
          chk("strobe_in_valid", {pi_aleh, pi_alel, pi_read | pi_write}, 3'b001);
        if (!pi_read && p_read) begin
          n_rpulse++;
          pi_ad_in = 16'hC000 + 16'(rd_idx * 273);
          rd_idx++;
          rd_q.push_back(pi_ad_in);
        end
        if (!pi_write && p_write) begin
          n_wpulse++;
          wd = pi_ad_out;
          wr_bad = 0;
        end
        if (!pi_write && pi_ad_out !== wd) wr_bad = 1;
        if (pi_write && !p_write) begin
          chk("wdata_stable_low", {31'd0, wr_bad}, 0);
          if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
          else chk("write_data", {16'd0, wd}, {16'd0, wr_q.pop_front()});
        end
        if (rdata_valid) begin
          n_rdv++;
          if (rd_q.size() == 0) chk("unexpected_rdata", 1, 0);
          else chk("rdata", {16'd0, rdata}, {16'd0, rd_q.pop_front()});
        end
      end
      p_aleh = pi_aleh; p_alel = pi_alel; p_read = pi_read; p_write = pi_write;
    end
  end

  // Write-data source with an optional one-shot stall before a chosen word.
  initial begin
    logic acc_pending;
    acc_pending = 0;
    forever begin
      @(negedge clk);
      if (acc_pending) begin
        void'(wfeed_q.pop_front());
        wcnt++;
        acc_pending = 0;
      end
      if (wcnt == stall_at && stall_len > 0) begin
        stall_len--;
        wdata_valid = 0;
      end else if (wfeed_q.size() != 0) begin
        wdata_valid = 1;
        wdata = wfeed_q[0];
      end else begin
        wdata_valid = 0;
      end
      if (wdata_valid && wdata_ready && !reset) acc_pending = 1;
    end
  end

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
    int k;
    k = 0;
    cmd_write = w; cmd_address = a; cmd_length = l; cmd_valid = 1;
    while (!cmd_ready && k < 2000) begin @(negedge clk); k++; end
    chk("cmd_accept", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 5000) begin @(negedge clk); k++; end
    chk(tag, {31'd0, busy}, 0);
  endtask

  initial begin
    int ph0, rp0, wp0, rv0, bad, k;
    // Reset state
    #12;
    chk("rst_aleh", {31'd0, pi_aleh}, 1);
    chk("rst_alel", {31'd0, pi_alel}, 0);
    chk("rst_strobes", {30'd0, pi_read, pi_write}, 2'b11);
    chk("rst_oe", {31'd0, pi_ad_oe}, 0);
    chk("rst_ad_out", {16'd0, pi_ad_out}, 0);
    chk("rst_flags", {29'd0, wdata_ready, rdata_valid, busy}, 0);
    @(negedge clk); reset = 0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);

    // Read burst of four halfwords, single address phase
    ph0 = n_phase; rp0 = n_rpulse; rv0 = n_rdv;
    exp_addr_q.push_back(32'h1000_0000);
    send_cmd(0, 32'h1000_0000, 8'd3);
    wait_idle("rd4_done");
    chk("rd4_phases", n_phase - ph0, 1);
    chk("rd4_pulses", n_rpulse - rp0, 4);
    chk("rd4_rdv", n_rdv - rv0, 4);
    chk("rd4_oe_off", {31'd0, pi_ad_oe}, 0);

    // Write with odd address, bit0 forced low
    ph0 = n_phase; wp0 = n_wpulse;
    exp_addr_q.push_back(32'h1FFF_0002);
    wr_q.push_back(16'hA5A5); wr_q.push_back(16'h5A5A);
    wfeed_q.push_back(16'hA5A5); wfeed_q.push_back(16'h5A5A);
    send_cmd(1, 32'h1FFF_0003, 8'd1);
    wait_idle("wr2_done");
    chk("wr2_phases", n_phase - ph0, 1);
    chk("wr2_pulses", n_wpulse - wp0, 2);
    chk("wr2_queue", wr_q.size(), 0);

    // Write stalled 50 cycles before the second halfword
    ph0 = n_phase; wp0 = n_wpulse;
    wcnt = 0; stall_at = 1; stall_len = 50;
    exp_addr_q.push_back(32'h2000_0000);
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back(16'h1230 + 16'(i));
      wfeed_q.push_back(16'h1230 + 16'(i));
    end
    send_cmd(1, 32'h2000_0000, 8'd2);
    k = 0;
    while ((n_wpulse - wp0 < 1 || !pi_write) && k < 2000) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    chk("stall_write_high", {31'd0, pi_write}, 1);
    chk("stall_mode_valid", {30'd0, pi_aleh, pi_alel}, 0);
    chk("stall_ready", {31'd0, wdata_ready}, 1);
    chk("stall_pulses", n_wpulse - wp0, 1);
    wait_idle("wr3_done");
    chk("wr3_pulses", n_wpulse - wp0, 3);
    chk("wr3_queue", wr_q.size(), 0);

    // Read across a 512-byte boundary
    ph0 = n_phase; rp0 = n_rpulse;
    exp_addr_q.push_back(32'h1000_01FC);
`ifdef N64_PI_HOST_PAGE_SPLIT_EN
    exp_addr_q.push_back(32'h1000_0200);
`endif
    send_cmd(0, 32'h1000_01FC, 8'd3);
    wait_idle("page_done");
`ifdef N64_PI_HOST_PAGE_SPLIT_EN
    chk("page_phases", n_phase - ph0, 2);
`else
    chk("page_phases", n_phase - ph0, 1);
`endif
    chk("page_pulses", n_rpulse - rp0, 4);
    chk("page_rd_q", rd_q.size(), 0);

    // Reset during the read strobe
    exp_addr_q.push_back(32'h1000_0040);
    send_cmd(0, 32'h1000_0040, 8'd2);
    k = 0;
    while (pi_read && k < 2000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("abort_in_strobe", {31'd0, pi_read}, 0);
    reset = 1;
    #1;
    chk("abort_outputs", {24'd0, pi_aleh, pi_alel, pi_read, pi_write, pi_ad_oe, busy, wdata_ready, rdata_valid},
        8'b1011_0000);
    rd_q.delete();
    rv0 = n_rdv;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_rdv", n_rdv - rv0, 0);
    ph0 = n_phase; rp0 = n_rpulse;
    exp_addr_q.push_back(32'h1000_0010);
    send_cmd(0, 32'h1000_0010, 8'd0);
    wait_idle("post_abort_done");
    chk("post_abort_rdv", n_rdv - rv0, 1);
    chk("post_abort_pulses", n_rpulse - rp0, 1);

    // cmd_valid held through a busy transaction
    ph0 = n_phase; bad = 0; k = 0;
    exp_addr_q.push_back(32'h1000_0100);
    exp_addr_q.push_back(32'h1000_0200);
    cmd_write = 0; cmd_address = 32'h1000_0100; cmd_length = 0; cmd_valid = 1;
    @(negedge clk);
    chk("hold_first_busy", {31'd0, busy}, 1);
    cmd_address = 32'h1000_0200;
    while (busy && k < 2000) begin
      if (cmd_ready) bad++;
      @(negedge clk); k++;
    end
    chk("hold_ready_low", bad, 0);
    chk("hold_idle_ready", {31'd0, cmd_ready}, 1);
    @(negedge clk);
    chk("hold_second_accepted", {31'd0, busy}, 1);
    cmd_valid = 0;
    wait_idle("hold_done");
    chk("hold_phases", n_phase - ph0, 2);
    chk("final_addr_q", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
